extbus_responder: RTL

EXTBUS_RESPONDER -- requirements
Module: extbus_responder

---
 rtl/extbus_pkg.sv | 26 ++
 rtl/extbus_sync.sv | 28 ++
 rtl/extbus_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/extbus_pkg.sv
// Shared definitions for the external-bus VRAM responder: register offsets,
// sequencer states and the address-increment decode.
package extbus_pkg;

  localparam logic [4:0] REG_ADDR_L = 5'd0;
  localparam logic [4:0] REG_ADDR_M = 5'd1;
  localparam logic [4:0] REG_ADDR_H = 5'd2;
  localparam logic [4:0] REG_DATA0  = 5'd3;
  localparam logic [4:0] REG_DATA1  = 5'd4;
  localparam logic [4:0] REG_CTRL   = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_PREFETCH = 2'd2
  } state_e;

  // incr = 0 means "no step"; otherwise the step is a power of two.
  function automatic logic [16:0] incr_step(input logic [3:0] incr);
    logic [16:0] step;
    step = '0;
    if (incr != 4'd0) step = 17'd1 << (incr - 4'd1);
    return step;
  endfunction

endpackage

// File: rtl/extbus_sync.sv
// Two-flop synchronizer for one bus strobe; pulses for one cycle when the
// synchronized strobe deasserts, i.e. once at the end of each bus cycle.
module extbus_sync (
  input  logic clk25,
  input  logic rst_n,
  input  logic strobe_i,
  output logic stage1_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= strobe_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign stage1_o = s1_q;
  assign fall_o   = s3_q & ~s2_q;

endmodule

// File: rtl/extbus_responder.sv
// Register window onto VRAM: two auto-incrementing address ports with read
// prefetch, driven by an asynchronous CPU-style bus.
module extbus_responder
  import extbus_pkg::*;
(
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        extbus_cs_n,
  input  logic        extbus_rd_n,
  input  logic        extbus_wr_n,
  input  logic [4:0]  extbus_a,
  input  logic [7:0]  extbus_d_in,
  output logic [7:0]  extbus_d_out,
  output logic        extbus_d_oe,
  output logic [16:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_write,
  output logic        vram_req,
  input  logic        vram_ack,
  input  logic [7:0]  vram_rddata
);

  logic wr_s1, wr_evt, rd_s1, rd_evt;

  extbus_sync u_wr_sync (
    .clk25(clk25), .rst_n(rst_n), .strobe_i(~extbus_cs_n & ~extbus_wr_n),
    .stage1_o(wr_s1), .fall_o(wr_evt)
  );

  extbus_sync u_rd_sync (
    .clk25(clk25), .rst_n(rst_n), .strobe_i(~extbus_cs_n & ~extbus_rd_n),
    .stage1_o(rd_s1), .fall_o(rd_evt)
  );

  logic [4:0]  a_cap_q;
  logic [7:0]  d_cap_q;
  logic [16:0] addr_q [2], addr_d [2];
  logic [3:0]  incr_q [2], incr_d [2];
  logic [7:0]  latch_q [2], latch_d [2];
  logic        sel_q, sel_d;

  logic        pend_valid_q, pend_valid_d, pend_write_q, pend_write_d;
  logic        pend_port_q, pend_port_d;
  logic [16:0] pend_waddr_q, pend_waddr_d, pend_paddr_q, pend_paddr_d;
  logic [7:0]  pend_data_q, pend_data_d;

  state_e      state_q, state_d;
  logic        req_q, req_d, cur_port_q, cur_port_d;
  logic [16:0] cur_addr_q, cur_addr_d, cur_paddr_q, cur_paddr_d;
  logic [7:0]  cur_data_q, cur_data_d;

  logic        ev_valid, ev_write, ev_port, dp;
  logic [16:0] ev_waddr, ev_paddr;

  // Address is also captured during reads so DATAx read events know their port.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      a_cap_q <= '0;
      d_cap_q <= '0;
    end else begin
      if (wr_s1 | rd_s1) a_cap_q <= extbus_a;
      if (wr_s1) d_cap_q <= extbus_d_in;
    end
  end

  assign dp = (a_cap_q == REG_DATA1);

  always_comb begin
    addr_d   = addr_q;
    incr_d   = incr_q;
    sel_d    = sel_q;
    ev_valid = 1'b0;
    ev_write = 1'b0;
    ev_port  = 1'b0;
    ev_waddr = '0;
    ev_paddr = '0;
    if (wr_evt) begin
      case (a_cap_q)
        REG_ADDR_L, REG_ADDR_M, REG_ADDR_H: begin
          if (a_cap_q == REG_ADDR_L) addr_d[sel_q][7:0] = d_cap_q;
          else if (a_cap_q == REG_ADDR_M) addr_d[sel_q][15:8] = d_cap_q;
          else begin
            incr_d[sel_q]     = d_cap_q[7:4];
            addr_d[sel_q][16] = d_cap_q[0];
          end
          ev_valid = 1'b1;
          ev_port  = sel_q;
          ev_paddr = addr_d[sel_q];
        end
        REG_DATA0, REG_DATA1: begin
          addr_d[dp] = addr_q[dp] + incr_step(incr_q[dp]);
          ev_valid   = 1'b1;
          ev_write   = 1'b1;
          ev_port    = dp;
          ev_waddr   = addr_q[dp];
          ev_paddr   = addr_d[dp];
        end
        REG_CTRL: sel_d = d_cap_q[0];
        default: ;
      endcase
    end else if (rd_evt && (a_cap_q == REG_DATA0 || a_cap_q == REG_DATA1)) begin
      addr_d[dp] = addr_q[dp] + incr_step(incr_q[dp]);
      ev_valid   = 1'b1;
      ev_port    = dp;
      ev_paddr   = addr_d[dp];
    end
  end

  // The slot is drained by IDLE first, so an event in the same cycle can refill it.
  always_comb begin
    pend_valid_d = pend_valid_q & (state_q != ST_IDLE);
    pend_write_d = pend_write_q;
    pend_port_d  = pend_port_q;
    pend_waddr_d = pend_waddr_q;
    pend_paddr_d = pend_paddr_q;
    pend_data_d  = pend_data_q;
    if (ev_valid && (!pend_valid_d ||
        (!ev_write && !pend_write_q && pend_port_q == ev_port))) begin
      pend_valid_d = 1'b1;
      pend_write_d = ev_write;
      pend_port_d  = ev_port;
      pend_waddr_d = ev_waddr;
      pend_paddr_d = ev_paddr;
      pend_data_d  = d_cap_q;
    end

    state_d     = state_q;
    req_d       = req_q;
    cur_port_d  = cur_port_q;
    cur_addr_d  = cur_addr_q;
    cur_paddr_d = cur_paddr_q;
    cur_data_d  = cur_data_q;
    latch_d     = latch_q;
    case (state_q)
      ST_IDLE: if (pend_valid_q) begin
        cur_port_d  = pend_port_q;
        cur_paddr_d = pend_paddr_q;
        cur_data_d  = pend_data_q;
        cur_addr_d  = pend_write_q ? pend_waddr_q : pend_paddr_q;
        state_d     = pend_write_q ? ST_WRITE : ST_PREFETCH;
      end
      ST_WRITE: begin
        if (!req_q) req_d = 1'b1;
        else if (vram_ack) begin
          req_d      = 1'b0;
          cur_addr_d = cur_paddr_q;
          state_d    = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        if (!req_q) req_d = 1'b1;
        else if (vram_ack) begin
          req_d               = 1'b0;
          latch_d[cur_port_q] = vram_rddata;
          state_d             = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        incr_q[i]  <= '0;
        latch_q[i] <= '0;
      end
      sel_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_port_q  <= 1'b0;
      pend_waddr_q <= '0;
      pend_paddr_q <= '0;
      pend_data_q  <= '0;
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      cur_port_q   <= 1'b0;
      cur_addr_q   <= '0;
      cur_paddr_q  <= '0;
      cur_data_q   <= '0;
    end else begin
      addr_q       <= addr_d;
      incr_q       <= incr_d;
      latch_q      <= latch_d;
      sel_q        <= sel_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      pend_port_q  <= pend_port_d;
      pend_waddr_q <= pend_waddr_d;
      pend_paddr_q <= pend_paddr_d;
      pend_data_q  <= pend_data_d;
      state_q      <= state_d;
      req_q        <= req_d;
      cur_port_q   <= cur_port_d;
      cur_addr_q   <= cur_addr_d;
      cur_paddr_q  <= cur_paddr_d;
      cur_data_q   <= cur_data_d;
    end
  end

  assign vram_req    = req_q;
  assign vram_write  = (state_q == ST_WRITE);
  assign vram_addr   = cur_addr_q;
  assign vram_wrdata = cur_data_q;
  assign extbus_d_oe = ~extbus_cs_n & ~extbus_rd_n;

  always_comb begin
    extbus_d_out = '0;
    case (extbus_a)
      REG_ADDR_L: extbus_d_out = addr_q[sel_q][7:0];
      REG_ADDR_M: extbus_d_out = addr_q[sel_q][15:8];
      REG_ADDR_H: extbus_d_out = {incr_q[sel_q], 3'b000, addr_q[sel_q][16]};
      REG_DATA0:  extbus_d_out = latch_q[0];
      REG_DATA1:  extbus_d_out = latch_q[1];
      REG_CTRL:   extbus_d_out = {7'b0, sel_q};
      default:    extbus_d_out = '0;
    endcase
  end

endmodule
